// File: rtl/led_matrix_capture_pkg.sv
// Shared definitions for the LED matrix capture path: capture FSM states,
// default geometry (shared with the display driver) and the row-select decoder.
package led_matrix_capture_pkg;

   localparam int unsigned LMC_ROWS    = 3;
   localparam int unsigned LMC_COLS    = 8;
   localparam int unsigned LMC_ROW_MAX = 32;

   typedef enum logic [0:0] {
      SEARCH,
      TRACK
   } cap_state_t;

   typedef struct packed {
      logic       valid;
      logic [4:0] idx;
   } row_dec_t;

   // One-hot validity check plus index of the selected row.
   function automatic row_dec_t row_decode(input logic [LMC_ROW_MAX-1:0] sel);
      row_dec_t d;
      d.valid = (sel != '0) && ((sel & (sel - 1'b1)) == '0);
      d.idx   = '0;
      for (int unsigned i = 0; i < LMC_ROW_MAX; i++) begin
         if (sel[i]) d.idx = 5'(i);
      end
      return d;
   endfunction

endpackage

// File: rtl/led_matrix_capture_filter.sv
// Input sampling and glitch filter for the LED matrix capture path.
// Emits one accept per stable period of the {row, col} pair.
// Define LED_MATRIX_CAPTURE_SYNC_EN to add a 2-flop synchronizer on the inputs.
module led_capture_filter
   import led_matrix_capture_pkg::*;
#(
   parameter int unsigned ROWS          = LMC_ROWS,
   parameter int unsigned COLS          = LMC_COLS,
   parameter int unsigned STABLE_CYCLES = 4
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [ROWS-1:0] row_in,
   input  logic [COLS-1:0] col_in,
   output logic            accept,
   output logic [ROWS-1:0] accept_row,
   output logic [COLS-1:0] accept_col
);

   localparam int unsigned PW = ROWS + COLS;
   localparam int unsigned SW = $clog2(STABLE_CYCLES + 1);

   logic [PW-1:0] p;
   logic [PW-1:0] p_prev;
   logic [SW-1:0] stab_cnt;
   logic          acc_done;

`ifdef LED_MATRIX_CAPTURE_SYNC_EN
   logic [PW-1:0] sync_q1;
   logic [PW-1:0] sync_q2;

   // Two-stage synchronizer for an asynchronous display driver.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_q1 <= '0;
         sync_q2 <= '0;
      end else begin
         sync_q1 <= {row_in, col_in};
         sync_q2 <= sync_q1;
      end
   end

   assign p = sync_q2;
`else
   assign p = {row_in, col_in};
`endif

   // Sample register, stability counter and accept-once flag.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         p_prev   <= '0;
         stab_cnt <= '0;
         acc_done <= 1'b0;
      end else begin
         p_prev <= p;
         if (p != p_prev) begin
            stab_cnt <= '0;
            acc_done <= 1'b0;
         end else begin
            if (stab_cnt != SW'(STABLE_CYCLES)) stab_cnt <= stab_cnt + 1'b1;
            if (accept) acc_done <= 1'b1;
         end
      end
   end

   // p_prev holds stab_cnt+1 identical samples, so the accept is raised from
   // registered state once that run length reaches STABLE_CYCLES.
   assign accept     = !acc_done && (stab_cnt == SW'(STABLE_CYCLES - 1));
   assign accept_row = p_prev[PW-1:COLS];
   assign accept_col = p_prev[COLS-1:0];

endmodule

// File: rtl/led_matrix_capture.sv
// LED matrix capture top: demultiplexes filtered rows into a full frame,
// tracks scan order, flags malformed/out-of-order rows and loss of scan.
// Optional input synchronizer: LED_MATRIX_CAPTURE_SYNC_EN (in led_capture_filter).
module led_matrix_capture
   import led_matrix_capture_pkg::*;
#(
   parameter int unsigned ROWS           = LMC_ROWS,
   parameter int unsigned COLS           = LMC_COLS,
   parameter int unsigned STABLE_CYCLES  = 4,
   parameter int unsigned TIMEOUT_CYCLES = 1024
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [ROWS-1:0]      row_in,
   input  logic [COLS-1:0]      col_in,
   output logic [ROWS*COLS-1:0] frame,
   output logic                 frame_valid,
   output logic                 frame_strobe,
   output logic                 row_err,
   output logic                 link_lost
);

   localparam int unsigned ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;
   localparam int unsigned TO_W  = $clog2(TIMEOUT_CYCLES + 1);

   logic                   accept;
   logic [ROWS-1:0]        acc_row;
   logic [COLS-1:0]        acc_col;
   logic [LMC_ROW_MAX-1:0] row_ext;
   row_dec_t               dec;
   logic [ROW_W-1:0]       acc_idx;
   logic [ROW_W-1:0]       next_idx;

   cap_state_t             state, state_n;
   logic [ROWS-1:0]        seen, seen_n;
   logic [ROW_W-1:0]       last_row, last_n;
   logic [TO_W-1:0]        to_cnt, to_n;
   logic [ROWS*COLS-1:0]   frame_n;
   logic                   valid_n, strobe_n, err_n, lost_n;

   led_capture_filter #(
      .ROWS          (ROWS),
      .COLS          (COLS),
      .STABLE_CYCLES (STABLE_CYCLES)
   ) u_filter (
      .clk        (clk),
      .rst        (rst),
      .row_in     (row_in),
      .col_in     (col_in),
      .accept     (accept),
      .accept_row (acc_row),
      .accept_col (acc_col)
   );

   assign row_ext  = LMC_ROW_MAX'(acc_row);
   assign dec      = row_decode(row_ext);
   assign acc_idx  = ROW_W'(dec.idx);
   assign next_idx = (last_row == ROW_W'(ROWS - 1)) ? '0 : last_row + 1'b1;

   // Capture FSM state, seen mask, frame and timeout registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= SEARCH;
         seen         <= '0;
         last_row     <= '0;
         to_cnt       <= '0;
         frame        <= '0;
         frame_valid  <= 1'b0;
         frame_strobe <= 1'b0;
         row_err      <= 1'b0;
         link_lost    <= 1'b0;
      end else begin
         state        <= state_n;
         seen         <= seen_n;
         last_row     <= last_n;
         to_cnt       <= to_n;
         frame        <= frame_n;
         frame_valid  <= valid_n;
         frame_strobe <= strobe_n;
         row_err      <= err_n;
         link_lost    <= lost_n;
      end
   end

   // Next-state: a valid row accept takes priority over the timeout.
   always_comb begin
      state_n  = state;
      seen_n   = seen;
      last_n   = last_row;
      to_n     = to_cnt;
      frame_n  = frame;
      valid_n  = frame_valid;
      lost_n   = link_lost;
      strobe_n = 1'b0;
      err_n    = 1'b0;

      if (accept && dec.valid) begin
         to_n = '0;
         for (int unsigned i = 0; i < ROWS; i++) begin
            if (acc_row[i]) frame_n[i*COLS +: COLS] = acc_col;
         end
         case (state)
            SEARCH: begin
               seen_n  = acc_row;
               last_n  = acc_idx;
               state_n = TRACK;
               lost_n  = 1'b0;
            end
            TRACK: begin
               if (acc_idx == last_row) begin
                  seen_n = seen;
               end else if (acc_idx == next_idx) begin
                  seen_n = seen | acc_row;
                  last_n = acc_idx;
               end else begin
                  err_n  = 1'b1;
                  seen_n = acc_row;
                  last_n = acc_idx;
               end
            end
            default: state_n = SEARCH;
         endcase
         if (&seen_n) begin
            strobe_n = 1'b1;
            valid_n  = 1'b1;
            seen_n   = '0;
         end
      end else begin
         if (accept && (acc_row != '0)) err_n = 1'b1;
         if (to_cnt == TO_W'(TIMEOUT_CYCLES - 1)) begin
            to_n    = to_cnt + 1'b1;
            lost_n  = 1'b1;
            valid_n = 1'b0;
            seen_n  = '0;
            state_n = SEARCH;
         end else if (to_cnt != TO_W'(TIMEOUT_CYCLES)) begin
            to_n = to_cnt + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_led_matrix_capture.sv
// Directed self-checking bench for led_matrix_capture (STABLE_CYCLES=4, TIMEOUT_CYCLES=64).
module tb_led_matrix_capture;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [2:0]  row_in = '0;
   logic [7:0]  col_in = '0;
   logic [23:0] frame;
   logic        frame_valid;
   logic        frame_strobe;
   logic        row_err;
   logic        link_lost;

   int unsigned checks = 0;
   int unsigned errors = 0;
   int unsigned n_strobe;
   int unsigned n_err;
   logic        saw_ff;
   logic [23:0] strobe_frame;

   led_matrix_capture #(
      .ROWS           (3),
      .COLS           (8),
      .STABLE_CYCLES  (4),
      .TIMEOUT_CYCLES (64)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .row_in       (row_in),
      .col_in       (col_in),
      .frame        (frame),
      .frame_valid  (frame_valid),
      .frame_strobe (frame_strobe),
      .row_err      (row_err),
      .link_lost    (link_lost)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic clr_mon();
      n_strobe     = 0;
      n_err        = 0;
      saw_ff       = 1'b0;
      strobe_frame = '0;
   endtask

   // Drive a row/column pair for n clocks, sampling pulses 1 ns after each edge.
   task automatic hold(input logic [2:0] r, input logic [7:0] c, input int unsigned n);
      row_in = r;
      col_in = c;
      for (int unsigned k = 0; k < n; k++) begin
         @(posedge clk);
         #1;
         if (frame_strobe) begin
            n_strobe++;
            strobe_frame = frame;
         end
         if (row_err) n_err++;
         if (frame[7:0] == 8'hFF) saw_ff = 1'b1;
      end
   endtask

   initial begin
      clr_mon();
      // Reset state
      repeat (3) @(posedge clk);
      #1;
      check("rst_frame", 32'(frame), 32'h0);
      check("rst_valid", 32'(frame_valid), 32'h0);
      check("rst_strobe", 32'(frame_strobe), 32'h0);
      check("rst_err", 32'(row_err), 32'h0);
      check("rst_lost", 32'(link_lost), 32'h0);
      rst = 1'b0;
      hold(3'b000, 8'h00, 2);

      // Clean scan
      clr_mon();
      hold(3'b001, 8'h11, 8);
      hold(3'b010, 8'h22, 8);
      check("clean_no_early_strobe", n_strobe, 0);
      hold(3'b100, 8'h33, 8);
      check("clean_strobe", n_strobe, 1);
      check("clean_strobe_frame", 32'(strobe_frame), 32'h332211);
      check("clean_err", n_err, 0);
      check("clean_frame", 32'(frame), 32'h332211);
      check("clean_valid", 32'(frame_valid), 32'h1);

      // Glitch rejection inside a row hold
      clr_mon();
      hold(3'b001, 8'h11, 8);
      hold(3'b001, 8'hFF, 3);
      hold(3'b001, 8'h11, 8);
      check("glitch_never_ff", 32'(saw_ff), 32'h0);
      check("glitch_row0", 32'(frame[7:0]), 32'h11);
      hold(3'b010, 8'h22, 8);
      hold(3'b100, 8'h33, 8);
      check("glitch_err", n_err, 0);
      check("glitch_strobe", n_strobe, 1);

      // Malformed row select
      clr_mon();
      hold(3'b011, 8'h55, 8);
      check("malformed_err", n_err, 1);
      check("malformed_strobe", n_strobe, 0);
      check("malformed_frame", 32'(frame), 32'h332211);

      // Out-of-order row and resync
      clr_mon();
      hold(3'b001, 8'h44, 8);
      check("ooo_inorder_err", n_err, 0);
      hold(3'b100, 8'h66, 8);
      check("ooo_err", n_err, 1);
      check("ooo_frame", 32'(frame), 32'h662244);
      clr_mon();
      hold(3'b001, 8'h77, 8);
      check("ooo_no_strobe_row0", n_strobe, 0);
      hold(3'b010, 8'h88, 8);
      check("ooo_strobe_row1", n_strobe, 1);
      check("ooo_resync_err", n_err, 0);
      check("ooo_frame_final", 32'(frame), 32'h668877);

      // Timeout on blanking
      clr_mon();
      hold(3'b000, 8'h00, 50);
      check("to_not_early", 32'(link_lost), 32'h0);
      check("to_valid_before", 32'(frame_valid), 32'h1);
      hold(3'b000, 8'h00, 20);
      check("to_lost", 32'(link_lost), 32'h1);
      check("to_valid", 32'(frame_valid), 32'h0);
      check("to_frame_kept", 32'(frame), 32'h668877);
      check("to_blank_err", n_err, 0);

      // Recovery after loss
      clr_mon();
      hold(3'b001, 8'h0A, 8);
      check("rec_lost_clr", 32'(link_lost), 32'h0);
      check("rec_valid_low", 32'(frame_valid), 32'h0);
      hold(3'b010, 8'h0B, 8);
      check("rec_no_early_strobe", n_strobe, 0);
      hold(3'b100, 8'h0C, 8);
      check("rec_strobe", n_strobe, 1);
      check("rec_valid", 32'(frame_valid), 32'h1);
      check("rec_frame", 32'(frame), 32'h0C0B0A);

      // Asynchronous reset mid-scan
      clr_mon();
      hold(3'b001, 8'h5A, 8);
      hold(3'b010, 8'h5B, 3);
      #2;
      rst = 1'b1;
      #1;
      check("arst_frame", 32'(frame), 32'h0);
      check("arst_valid", 32'(frame_valid), 32'h0);
      check("arst_lost", 32'(link_lost), 32'h0);
      row_in = '0;
      col_in = '0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      clr_mon();
      hold(3'b010, 8'h5B, 8);
      hold(3'b100, 8'h5C, 8);
      check("arst_no_early_strobe", n_strobe, 0);
      hold(3'b001, 8'h5D, 8);
      check("arst_strobe", n_strobe, 1);
      check("arst_err", n_err, 0);
      check("arst_frame_final", 32'(frame), 32'h5C5B5D);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
